// File: rtl/sum_nb_seq_if.sv
// ============================================================================
// Module : sum_nb_seq_if
// Start/busy/done handshake and operand/result bus of the digit-serial adder.
// The ovf signal exists only when SUM_U2_OVF_EN is defined.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface sum_nb_seq_if #(
   parameter int WIDTH = 8
) ();
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             wej_przen;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             wyj_przen;
`ifdef SUM_U2_OVF_EN
   logic             ovf;
`endif

   modport master (
      output start, a, b, wej_przen,
      input  busy, done, sum, wyj_przen
`ifdef SUM_U2_OVF_EN
      , ovf
`endif
   );

   modport slave (
      input  start, a, b, wej_przen,
      output busy, done, sum, wyj_przen
`ifdef SUM_U2_OVF_EN
      , ovf
`endif
   );
endinterface

`default_nettype wire

// File: rtl/sum_nb_seq.sv
// ============================================================================
// Module : sum_nb_seq
// Digit-serial two's-complement adder, DIGIT bits per clock, registered carry.
// Optional U2 overflow output enabled by defining SUM_U2_OVF_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sum_nb_seq #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 2
) (
   input  wire logic   clk,
   input  wire logic   rst,
   sum_nb_seq_if.slave bus
);
   localparam int              c_N     = WIDTH / DIGIT;
   localparam int              c_KW    = (c_N > 1) ? $clog2(c_N) : 1;
   localparam logic [c_KW-1:0] c_KLAST = c_KW'(c_N - 1);

   generate
      if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
         $error("sum_nb_seq: WIDTH must be a positive multiple of DIGIT");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                 r_state;
   logic [WIDTH-1:0]       r_a;
   logic [WIDTH-1:0]       r_b;
   logic [WIDTH-1:0]       r_res;
   logic [WIDTH-1:0]       r_sum;
   logic                   r_c;
   logic                   r_cout;
   logic                   r_busy;
   logic                   r_done;
   logic [c_KW-1:0]        r_k;
   logic [DIGIT:0]         w_dadd;
   logic [WIDTH+DIGIT-1:0] w_cat;
   logic [WIDTH-1:0]       w_res_next;

   // Operands shift right so the active digit always sits in the low bits;
   // result digits enter at the top and reach their final place after N steps.
   assign w_dadd     = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]} + {{DIGIT{1'b0}}, r_c};
   assign w_cat      = {w_dadd[DIGIT-1:0], r_res};
   assign w_res_next = WIDTH'(w_cat >> DIGIT);

`ifdef SUM_U2_OVF_EN
   logic r_ovf;
   logic w_ovf_next;

   // On the last step the low digit bits hold the operand MSBs.
   assign w_ovf_next = (r_a[DIGIT-1] == r_b[DIGIT-1]) && (w_dadd[DIGIT-1] != r_a[DIGIT-1]);
   assign bus.ovf    = r_ovf;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_res   <= '0;
         r_sum   <= '0;
         r_c     <= 1'b0;
         r_cout  <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_k     <= '0;
`ifdef SUM_U2_OVF_EN
         r_ovf   <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               r_done <= 1'b0;
               if (bus.start) begin
                  r_a     <= bus.a;
                  r_b     <= bus.b;
                  r_c     <= bus.wej_przen;
                  r_k     <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_RUN;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_RUN: begin
               r_a   <= r_a >> DIGIT;
               r_b   <= r_b >> DIGIT;
               r_c   <= w_dadd[DIGIT];
               r_res <= w_res_next;
               if (r_k == c_KLAST) begin
                  r_sum   <= w_res_next;
                  r_cout  <= w_dadd[DIGIT];
`ifdef SUM_U2_OVF_EN
                  r_ovf   <= w_ovf_next;
`endif
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_k <= r_k + 1'b1;
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.sum       = r_sum;
   assign bus.wyj_przen = r_cout;

endmodule

`default_nettype wire

// File: tb/tb_sum_nb_seq.sv
// ============================================================================
// Module : tb_sum_nb_seq
// Self-checking bench for sum_nb_seq: 8/2 instance with cycle model, 4/1 and 4/4 sweeps.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_sum_nb_seq;
`ifdef SUM_U2_OVF_EN
   localparam logic OVF_ON = 1'b1;
`else
   localparam logic OVF_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   sum_nb_seq_if #(.WIDTH(8)) if8 ();
   sum_nb_seq_if #(.WIDTH(4)) if41 ();
   sum_nb_seq_if #(.WIDTH(4)) if44 ();

   sum_nb_seq #(.WIDTH(8), .DIGIT(2)) dut8  (.clk(clk), .rst(rst), .bus(if8));
   sum_nb_seq #(.WIDTH(4), .DIGIT(1)) dut41 (.clk(clk), .rst(rst), .bus(if41));
   sum_nb_seq #(.WIDTH(4), .DIGIT(4)) dut44 (.clk(clk), .rst(rst), .bus(if44));

   logic w8_ovf, w41_ovf, w44_ovf;
`ifdef SUM_U2_OVF_EN
   assign w8_ovf  = if8.ovf;
   assign w41_ovf = if41.ovf;
   assign w44_ovf = if44.ovf;
`else
   assign w8_ovf  = 1'b0;
   assign w41_ovf = 1'b0;
   assign w44_ovf = 1'b0;
`endif

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Behavioural model of the 8/2 instance: an accepted op completes N=4 edges later.
   int         m_rem  = 0;
   logic       m_done = 1'b0;
   logic [7:0] m_sum  = 8'h00;
   logic       m_c    = 1'b0;
   logic       m_ovf  = 1'b0;
   logic [7:0] p_sum  = 8'h00;
   logic       p_c    = 1'b0;
   logic       p_ov   = 1'b0;

   function automatic logic [9:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic cin);
      logic [8:0] s;
      s = {1'b0, a} + {1'b0, b} + {8'h00, cin};
      return {s, (a[7] == b[7]) && (s[7] != a[7])};
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_rem  <= 0;
         m_done <= 1'b0;
         m_sum  <= 8'h00;
         m_c    <= 1'b0;
         m_ovf  <= 1'b0;
      end else if (m_rem > 0) begin
         m_rem <= m_rem - 1;
         if (m_rem == 1) begin
            m_sum  <= p_sum;
            m_c    <= p_c;
            m_ovf  <= p_ov;
            m_done <= 1'b1;
         end
      end else begin
         m_done <= 1'b0;
         if (if8.start) begin
            {p_c, p_sum, p_ov} <= ref8(if8.a, if8.b, if8.wej_przen);
            m_rem <= 4;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("model_busy", 32'(if8.busy), 32'(m_rem > 0));
         chk("model_done", 32'(if8.done), 32'(m_done));
         chk("model_result", 32'({if8.wyj_przen, if8.sum, w8_ovf}), 32'({m_c, m_sum, m_ovf & OVF_ON}));
      end
   end

   task automatic lit(input string nm, input logic [7:0] s, input logic c, input logic ov);
      chk(nm, 32'({if8.wyj_przen, if8.sum, w8_ovf}), 32'({c, s, ov & OVF_ON}));
   endtask

   // Waits (bounded) for done; returns edges since accept and busy-cycle count.
   task automatic wait_done8(output int lat, output int bcnt);
      lat  = 0;
      bcnt = 0;
      while (!if8.done && lat < 20) begin
         if (if8.busy) bcnt++;
         @(negedge clk);
         lat++;
      end
      if (!if8.done) chk("done_timeout", 32'(lat), 32'd4);
   endtask

   task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                       output int lat, output int bcnt);
      @(negedge clk);
      if8.start = 1'b1; if8.a = a; if8.b = b; if8.wej_przen = cin;
      @(negedge clk);
      if8.start = 1'b0;
      wait_done8(lat, bcnt);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout");
      $fatal(1, "simulation time limit");
   end

   initial begin
      int         lat, bcnt, l1, l4, n;
      logic [8:0] v;
      logic [4:0] s5;
      logic [9:0] r41, r44;

      if8.start  = 1'b0; if8.a  = '0; if8.b  = '0; if8.wej_przen  = 1'b0;
      if41.start = 1'b0; if41.a = '0; if41.b = '0; if41.wej_przen = 1'b0;
      if44.start = 1'b0; if44.a = '0; if44.b = '0; if44.wej_przen = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("reset_busy_done", 32'({if8.busy, if8.done}), 32'd0);
      lit("reset_result", 8'h00, 1'b0, 1'b0);

      run8(8'h0F, 8'h01, 1'b0, lat, bcnt);
      chk("s1_latency", 32'(lat), 32'd4);
      chk("s1_busy_cycles", 32'(bcnt), 32'd4);
      lit("s1_result", 8'h10, 1'b0, 1'b0);

      run8(8'hFF, 8'h00, 1'b1, lat, bcnt);
      lit("s2_ff_00_c1", 8'h00, 1'b1, 1'b0);
      run8(8'h7F, 8'h01, 1'b0, lat, bcnt);
      lit("s2_7f_01", 8'h80, 1'b0, 1'b1);
      run8(8'h80, 8'h80, 1'b0, lat, bcnt);
      lit("s2_80_80", 8'h00, 1'b1, 1'b1);

      // Start ignored mid-RUN, then a back-to-back start in the DONE cycle.
      @(negedge clk);
      if8.start = 1'b1; if8.a = 8'h12; if8.b = 8'h34; if8.wej_przen = 1'b0;
      @(negedge clk);
      if8.start = 1'b0;
      @(negedge clk);
      if8.start = 1'b1; if8.a = 8'hFF; if8.b = 8'hFF;
      @(negedge clk);
      if8.start = 1'b0;
      wait_done8(lat, bcnt);
      lit("s3_first", 8'h46, 1'b0, 1'b0);
      if8.start = 1'b1; if8.a = 8'h01; if8.b = 8'h01;
      @(negedge clk);
      if8.start = 1'b0;
      chk("s3_b2b_busy", 32'({if8.busy, if8.done}), 32'd2);
      lit("s3_held", 8'h46, 1'b0, 1'b0);
      wait_done8(lat, bcnt);
      chk("s3_b2b_latency", 32'(lat), 32'd4);
      lit("s3_second", 8'h02, 1'b0, 1'b0);

      // Asynchronous reset in the middle of RUN.
      @(negedge clk);
      if8.start = 1'b1; if8.a = 8'hAA; if8.b = 8'h55;
      @(negedge clk);
      if8.start = 1'b0;
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("s4_rst_busy_done", 32'({if8.busy, if8.done}), 32'd0);
      lit("s4_rst_result", 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      if8.start = 1'b1; if8.a = 8'hFF; if8.b = 8'hFF;
      @(negedge clk);
      rst = 1'b0;
      if8.start = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("s4_no_done", 32'({if8.busy, if8.done}), 32'd0);
      end
      run8(8'h03, 8'h04, 1'b0, lat, bcnt);
      lit("s4_after_reset", 8'h07, 1'b0, 1'b0);

      // Exhaustive sweeps on the 4/1 and 4/4 instances in lockstep.
      for (int i = 0; i < 512; i++) begin
         v = 9'(i);
         @(negedge clk);
         if41.start = 1'b1; if41.a = v[3:0]; if41.b = v[7:4]; if41.wej_przen = v[8];
         if44.start = 1'b1; if44.a = v[3:0]; if44.b = v[7:4]; if44.wej_przen = v[8];
         @(negedge clk);
         if41.start = 1'b0;
         if44.start = 1'b0;
         l1 = -1; l4 = -1; n = 0; r41 = '0; r44 = '0;
         while ((l1 < 0 || l4 < 0) && n < 12) begin
            if (if41.done && l1 < 0) begin l1 = n; r41 = {if41.wyj_przen, if41.sum, w41_ovf}; end
            if (if44.done && l4 < 0) begin l4 = n; r44 = {if44.wyj_przen, if44.sum, w44_ovf}; end
            if (l1 < 0 || l4 < 0) begin
               @(negedge clk);
               n++;
            end
         end
         s5 = {1'b0, v[3:0]} + {1'b0, v[7:4]} + {4'h0, v[8]};
         chk($sformatf("sweep41_%0d", i), {8'(l1), 16'h0, 2'b00, r41[5:0]},
             {8'd4, 16'h0, 2'b00, s5, ((v[3] == v[7]) && (s5[3] != v[3])) & OVF_ON});
         chk($sformatf("sweep44_%0d", i), {8'(l4), 16'h0, 2'b00, r44[5:0]},
             {8'd1, 16'h0, 2'b00, s5, ((v[3] == v[7]) && (s5[3] != v[3])) & OVF_ON});
      end

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

`default_nettype wire
